// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution in EX: evaluates the condition, registers the redirect
// target and runs a short FLUSH sequence that squashes wrong-path fetches.
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            branch_i,
  input  logic            jump_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            stall_i,
  output logic            pc_src_o,
  output logic [XLEN-1:0] target_o,
  output logic            flush_o,
  output logic            busy_o
);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES);

  state_t          state;
  logic [2:0]      cnt;
  logic            eq;
  logic            lt_s;
  logic            lt_u;
  logic            cond;
  logic            taken;
  logic            accept;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] tgt;

  assign eq   = rs1_data_i == rs2_data_i;
  assign lt_s = $signed(rs1_data_i) < $signed(rs2_data_i);
  assign lt_u = rs1_data_i < rs2_data_i;

  always_comb begin
    cond = 1'b0;
    case (funct3_i)
      3'b000:  cond = eq;
      3'b001:  cond = ~eq;
      3'b100:  cond = lt_s;
      3'b101:  cond = ~lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = ~lt_u;
      default: cond = 1'b0;
    endcase
  end

  assign taken  = jump_i | (branch_i & cond);
  assign accept = valid_i & ~stall_i & (state == IDLE);
  assign sum    = pc_i + imm_i;
  assign tgt    = {sum[XLEN-1:1], 1'b0};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      pc_src_o <= 1'b0;
      flush_o  <= 1'b0;
      busy_o   <= 1'b0;
      target_o <= '0;
    end else if (state == IDLE) begin
      if (accept && taken) begin
        state    <= FLUSH;
        cnt      <= CNT_INIT;
        target_o <= tgt;
        pc_src_o <= 1'b1;
        flush_o  <= 1'b1;
        busy_o   <= 1'b1;
      end
    end else if (!stall_i) begin
      // a stalled cycle holds the redirect so fetch still sees it
      pc_src_o <= 1'b0;
      cnt      <= cnt - 3'd1;
      if (cnt == 3'd1) begin
        state   <= IDLE;
        flush_o <= 1'b0;
        busy_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected redirects are queued at
// issue and matched by a monitor on every flush pulse.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;

  typedef struct {
    logic [31:0] tgt;
    int          due;
    int          flen;
    int          plen;
  } rec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid = 1'b0;
  logic            branch = 1'b0;
  logic            jump = 1'b0;
  logic [2:0]      funct3 = 3'd0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic [XLEN-1:0] pc = '0;
  logic [XLEN-1:0] imm = '0;
  logic            stall = 1'b0;
  logic            pc_src;
  logic [XLEN-1:0] target;
  logic            flush;
  logic            busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  rec_t q[$];

  branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid),
    .branch_i   (branch),
    .jump_i     (jump),
    .funct3_i   (funct3),
    .rs1_data_i (rs1),
    .rs2_data_i (rs2),
    .pc_i       (pc),
    .imm_i      (imm),
    .stall_i    (stall),
    .pc_src_o   (pc_src),
    .target_o   (target),
    .flush_o    (flush),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor
  logic prev_f = 1'b0;
  bit   have = 1'b0;
  rec_t cur;
  int   flen = 0;
  int   plen = 0;

  always @(negedge clk) begin
    chk("busy_eq_flush", {31'd0, busy}, {31'd0, flush});
    if (flush && !prev_f) begin
      if (q.size() == 0) begin
        have = 1'b0;
        chk("unexpected_flush", 32'd1, 32'd0);
      end else begin
        cur  = q.pop_front();
        have = 1'b1;
        chk("target", target, cur.tgt);
        chk("latency", cyc, cur.due);
        chk("pc_src_first", {31'd0, pc_src}, 32'd1);
      end
      flen = 0;
      plen = 0;
    end
    if (pc_src && !flush) chk("pc_src_no_flush", 32'd1, 32'd0);
    if (flush) flen++;
    if (pc_src) plen++;
    if (!flush && prev_f && have) begin
      chk("flush_len", flen, cur.flen);
      chk("pc_src_len", plen, cur.plen);
      have = 1'b0;
    end
    prev_f = flush;
  end

  task automatic tick(input logic s);
    stall = s;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic jp, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] im);
    valid  = 1'b1;
    branch = br;
    jump   = jp;
    funct3 = f3;
    rs1    = a;
    rs2    = b;
    pc     = p;
    imm    = im;
  endtask

  task automatic idle_in();
    valid  = 1'b0;
    branch = 1'b0;
    jump   = 1'b0;
  endtask

  task automatic expect_redirect(input logic [31:0] t, input int fl,
                                 input int pl);
    rec_t r;
    r.tgt  = t;
    r.due  = cyc + 1;
    r.flen = fl;
    r.plen = pl;
    q.push_back(r);
  endtask

  task automatic gap(input int n);
    idle_in();
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  initial begin
    rst = 1'b1;
    tick(1'b0);
    tick(1'b0);
    @(negedge clk);
    chk("rst_pc_src", {31'd0, pc_src}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_target", target, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    gap(2);

    // BEQ taken
    drive(1, 0, 3'b000, 32'h5, 32'h5, 32'h100, 32'h20);
    expect_redirect(32'h120, 2, 1);
    tick(1'b0);
    gap(4);

    // BLT signed taken, BLTU not taken
    drive(1, 0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h10);
    expect_redirect(32'h210, 2, 1);
    tick(1'b0);
    gap(4);
    drive(1, 0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h8);
    tick(1'b0);
    gap(3);
    chk("bltu_hold_target", target, 32'h210);

    // JAL wrap and bit 0 clear
    drive(0, 1, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h21);
    expect_redirect(32'h10, 2, 1);
    tick(1'b0);
    gap(4);

    // BNE taken with 3-cycle stall from first FLUSH cycle
    drive(1, 0, 3'b001, 32'h1, 32'h2, 32'h400, 32'h40);
    expect_redirect(32'h440, 5, 4);
    tick(1'b0);
    idle_in();
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    gap(6);

    // wrong-path jumps ignored during FLUSH
    drive(1, 0, 3'b101, 32'h3, 32'h3, 32'h500, 32'hFFFF_FFFC);
    expect_redirect(32'h4FC, 2, 1);
    tick(1'b0);
    drive(0, 1, 3'b000, 32'h0, 32'h0, 32'h900, 32'h0);
    tick(1'b0);
    drive(0, 1, 3'b000, 32'h0, 32'h0, 32'h980, 32'h4);
    tick(1'b0);
    gap(3);
    chk("wrong_path_target", target, 32'h4FC);

    // jump on the FLUSH->IDLE cycle ignored, accepted the next cycle
    drive(1, 0, 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h600, 32'h100);
    expect_redirect(32'h700, 2, 1);
    tick(1'b0);
    idle_in();
    tick(1'b0);
    drive(0, 1, 3'b000, 32'h0, 32'h0, 32'h800, 32'h6);
    tick(1'b0);
    expect_redirect(32'h806, 2, 1);
    tick(1'b0);
    gap(4);

    // branch+jump: jump wins despite false condition
    drive(1, 1, 3'b000, 32'h1, 32'h2, 32'h1000, 32'h2);
    expect_redirect(32'h1002, 2, 1);
    tick(1'b0);
    gap(4);

    // never-taken codes and false BNE/BGE
    drive(1, 0, 3'b010, 32'h1, 32'h1, 32'h2000, 32'h4);
    tick(1'b0);
    drive(1, 0, 3'b011, 32'h1, 32'h2, 32'h2000, 32'h4);
    tick(1'b0);
    drive(1, 0, 3'b001, 32'h7, 32'h7, 32'h2000, 32'h4);
    tick(1'b0);
    drive(1, 0, 3'b101, 32'h8000_0000, 32'h0, 32'h2000, 32'h4);
    tick(1'b0);
    gap(3);
    chk("not_taken_hold_target", target, 32'h1002);

    // stalled valid in IDLE is not accepted
    drive(0, 1, 3'b000, 32'h0, 32'h0, 32'h3000, 32'h0);
    tick(1'b1);
    tick(1'b1);
    gap(3);
    chk("stall_idle_target", target, 32'h1002);

    // reset in first FLUSH cycle
    drive(1, 0, 3'b000, 32'h9, 32'h9, 32'hA00, 32'h10);
    expect_redirect(32'hA10, 1, 1);
    tick(1'b0);
    idle_in();
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("rst_mid_pc_src", {31'd0, pc_src}, 32'd0);
    chk("rst_mid_flush", {31'd0, flush}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_target", target, 32'd0);
    @(posedge clk);
    #1;
    gap(5);

    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
